// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 7-bit UART receiver.
//   DATA_W          - data bits per frame
//   uart_state_t    - receiver FSM state encoding
//   PAR_EVEN/PAR_ODD - encoding of the parity-select input
//   exp_parity()    - parity bit a transmitter sends for given data and mode
package uart_pkg;

  localparam int DATA_W = 7;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

  // Even parity makes the total count of ones even, odd parity makes it odd.
  function automatic logic exp_parity(input logic [DATA_W-1:0] data,
                                      input logic              sel);
    return (^data) ^ (sel == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
//   clk - receiver clock
//   rst - asynchronous active-low reset; both flops reset to 1 (line idle)
//   d   - asynchronous input
//   q   - synchronized output
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture; reset to the idle-high level so no false start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, frame = start(0), 7 data bits LSB first,
// parity, stop(1). Mid-bit sampling driven by a baud counter.
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-low reset
//   rxd        - serial line (idle high, asynchronous)
//   p_s        - parity select (0 even, 1 odd), latched at start detection
//   dout       - last received data word
//   valid      - one-cycle pulse qualifying dout/parity_err/frame_err
//   busy       - high from start detection until back in IDLE
//   parity_err - parity mismatch on the last frame
//   frame_err  - stop bit sampled low on the last frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              p_s,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic              rx_s;
  uart_state_t       state_r, state_nxt;
  logic [CW-1:0]     cnt_r, cnt_nxt;
  logic [2:0]        bit_idx_r, bit_idx_nxt;
  logic [DATA_W-1:0] shift_r;
  logic              par_sel_r;
  logic              par_bad_r;
  logic              stop_bad_r;
  logic              done_r;
  logic              start_s, shift_en_s, par_en_s, stop_en_s;
  logic [DATA_W-1:0] dout_r;
  logic              valid_r, busy_r, parity_err_r, frame_err_r;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rx_s)
  );

  // FSM state, baud counter and bit index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      bit_idx_r <= bit_idx_nxt;
    end
  end

  // Next-state logic; the counter wraps to zero at every sample point.
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    bit_idx_nxt = bit_idx_r;
    start_s     = 1'b0;
    shift_en_s  = 1'b0;
    par_en_s    = 1'b0;
    stop_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt = CNT_ZERO;
        if (!rx_s) begin
          state_nxt = ST_START;
          start_s   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_nxt = CNT_ZERO;
          if (rx_s) begin
            state_nxt = ST_IDLE;      // glitch shorter than half a bit
          end else begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = 3'd0;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt    = CNT_ZERO;
          shift_en_s = 1'b1;
          if (bit_idx_r == 3'd6) begin
            state_nxt = ST_PARITY;
          end else begin
            bit_idx_nxt = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt   = CNT_ZERO;
          par_en_s  = 1'b1;
          state_nxt = ST_STOP;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt   = CNT_ZERO;
          stop_en_s = 1'b1;
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_nxt = CNT_ZERO;
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Frame datapath: parity mode latch, shift register, parity/stop results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_sel_r  <= PAR_EVEN;
      shift_r    <= {DATA_W{1'b0}};
      par_bad_r  <= 1'b0;
      stop_bad_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (start_s) begin
        par_sel_r <= p_s;
      end
      if (shift_en_s) begin
        shift_r <= {rx_s, shift_r[DATA_W-1:1]};
      end
      if (par_en_s) begin
        par_bad_r <= (rx_s != exp_parity(shift_r, par_sel_r));
      end
      if (stop_en_s) begin
        stop_bad_r <= ~rx_s;
      end
      // Results are published one clock after the stop sample.
      done_r <= stop_en_s;
    end
  end

  // Registered outputs; results hold until the next completed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r       <= {DATA_W{1'b0}};
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      valid_r <= done_r;
      busy_r  <= (state_nxt != ST_IDLE);
      if (done_r) begin
        dout_r       <= shift_r;
        parity_err_r <= par_bad_r;
        frame_err_r  <= stop_bad_r;
      end
    end
  end

  assign dout       = dout_r;
  assign valid      = valid_r;
  assign busy       = busy_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed self-checking bench for uart_rx
// with CLKS_PER_BIT = 4. A transaction-level model predicts, for every
// frame sent, the data word, error flags and the clock edge of valid.
module tb_uart_rx;

  localparam int C   = 4;
  localparam int LAT = 2 + C / 2 + 9 * C + 1;

  typedef struct {
    logic [6:0] d;
    logic       pe;
    logic       fe;
    int         t;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       p_s;
  logic [6:0] dout;
  logic       valid, busy, parity_err, frame_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .p_s        (p_s),
    .dout       (dout),
    .valid      (valid),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with the edge count at which it appeared.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      rec_t r;
      r.d  = dout;
      r.pe = parity_err;
      r.fe = frame_err;
      r.t  = cyc;
      obs_q.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; the model entry is built from the frame rules alone.
  task automatic send_frame(input logic [6:0] d, input logic psel, input logic flip,
                            input logic stop_bit, input int gap);
    logic [9:0] bits;
    logic       par;
    rec_t       r;
    int         st;
    st = 0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      rxd = 1'b1;
    end
    p_s  = psel;
    par  = (^d) ^ psel ^ flip;
    bits = {stop_bit, par, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(posedge clk); #1;
      rxd = bits[b];
      if (b == 0) st = cyc + 1;
      if (b == 1) p_s = 1'($urandom);
      repeat (C - 1) @(posedge clk);
    end
    r.d  = d;
    r.pe = flip;
    r.fe = ~stop_bit;
    r.t  = st + LAT;
    exp_q.push_back(r);
  endtask

  // Wait (bounded) for all predicted pulses, then compare in order.
  task automatic drain(input string tag);
    int   n;
    rec_t e, o, last;
    logic have;
    n    = 0;
    have = 1'b0;
    while (obs_q.size() < exp_q.size() && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * C) @(negedge clk);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_dout"}, 32'(o.d), 32'(e.d));
      check({tag, "_perr"}, 32'(o.pe), 32'(e.pe));
      check({tag, "_ferr"}, 32'(o.fe), 32'(e.fe));
      check({tag, "_time"}, 32'(o.t), 32'(e.t));
      last = e;
      have = 1'b1;
    end
    if (have) begin
      check({tag, "_hold_dout"}, 32'(dout), 32'(last.d));
      check({tag, "_hold_perr"}, 32'(parity_err), 32'(last.pe));
      check({tag, "_hold_ferr"}, 32'(frame_err), 32'(last.fe));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"},  32'(dout), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_perr"},  32'(parity_err), 32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw_busy;
    logic prev_bad;
    logic [6:0] d;
    logic ps, fl, sb;
    int gap;

    rst = 1'b0;
    rxd = 1'b1;
    p_s = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Good frame, even parity; then wrong parity bit for odd mode.
    send_frame(7'b0011011, 1'b0, 1'b0, 1'b1, 4);
    drain("even_ok");
    send_frame(7'b0011011, 1'b1, 1'b1, 1'b1, 4);
    drain("odd_bad");

    // One-clock glitch: start is rejected, busy falls quickly, no valid.
    @(posedge clk); #1; rxd = 1'b0;
    @(posedge clk); #1; rxd = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < C / 2 + 3; i++) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    check("glitch_busy_seen", 32'(saw_busy), 32'd1);
    check("glitch_busy_end", 32'(busy), 32'd0);
    drain("glitch");

    // Bad stop bit, line held low, then a clean frame.
    send_frame(7'h55, 1'b0, 1'b0, 1'b0, 4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("wait_idle_busy", 32'(busy), 32'd1);
    send_frame(7'h2A, 1'b0, 1'b0, 1'b1, 2 * C);
    drain("frame_err");

    // Reset in the middle of data bit 3, then a clean odd-parity frame.
    @(posedge clk); #1; rxd = 1'b0;
    repeat (C - 1) @(posedge clk);
    @(posedge clk); #1; rxd = 1'b1;
    repeat (4 * C) @(posedge clk);
    #1;
    check("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    send_frame(7'h7F, 1'b1, 1'b0, 1'b1, 2 * C);
    drain("after_rst");

    // Back-to-back frames, no idle gap: valids exactly 10 bits apart.
    send_frame(7'h01, 1'b0, 1'b0, 1'b1, 4);
    send_frame(7'h40, 1'b1, 1'b0, 1'b1, 0);
    send_frame(7'h00, 1'b0, 1'b0, 1'b1, 0);
    drain("b2b");

    // Random frames with random parity mode, parity and stop errors.
    prev_bad = 1'b0;
    for (int k = 0; k < 24; k++) begin
      d   = 7'($urandom);
      ps  = 1'($urandom);
      fl  = ($urandom_range(0, 3) == 0);
      sb  = ($urandom_range(0, 7) != 0);
      gap = prev_bad ? 2 * C : int'($urandom_range(0, 5));
      send_frame(d, ps, fl, sb, gap);
      prev_bad = ~sb;
    end
    @(posedge clk); #1; rxd = 1'b1;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
